// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_slave register-memory block.
package mem_pkg;

    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_MEM_SIZE    = 16;
    localparam int DEF_WAIT_CYCLES = 1;

    // The wait counter holds 0..15.
    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

    // A single-word request as presented by the master, at default widths.
    typedef struct packed {
        logic                      wr;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    // Width of a word index into storage of the given depth. It is never narrower than one bit.
    function automatic int idx_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage for mem_slave. It has one write port and one registered read port.
// The whole array and the read register clear synchronously on reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_SIZE   = DEF_MEM_SIZE,
    parameter int IDX_WIDTH  = idx_width(DEF_MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    // Storage update: reset wipes every word and wins over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read register: it loads on an in-range read, zeroes on a rejected read, and otherwise holds its value.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_slave.sv
// Single-request register-memory slave. It captures a request in IDLE and
// spends WAIT_CYCLES cycles in WAIT. It then performs the access in RESP and
// presents a registered one-cycle slv_rsp, with slv_err set for addresses beyond MEM_SIZE-1.
module mem_slave
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MEM_SIZE    = DEF_MEM_SIZE,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  slv_rsp,
    output logic                  slv_err
);

    localparam int IDX_WIDTH = idx_width(MEM_SIZE);

    // The limit is one bit wider than the address. MEM_SIZE therefore compares exactly even when it equals 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]  MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(WAIT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(1);

    mem_state_e            state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  wr_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  in_range_q;

    logic mem_we;
    logic mem_rd_en;
    logic mem_rd_clr;

    // The range check is done once, at capture time, against the full-width address.
    // Only the index bits need to be kept after that.
    logic in_range;
    assign in_range = ({1'b0, addr} < MEM_LIMIT);

    // Storage is touched only in RESP. Rejected writes never reach the array.
    // A rejected read zeroes the read register.
    assign mem_we     = (state == RESP) &&  wr_q &&  in_range_q;
    assign mem_rd_en  = (state == RESP) && !wr_q &&  in_range_q;
    assign mem_rd_clr = (state == RESP) && !wr_q && !in_range_q;

    // Request FSM: capture in IDLE, count wait states, then raise the registered response for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            in_range_q <= 1'b0;
            slv_rsp    <= 1'b0;
            slv_err    <= 1'b0;
        end else begin
            slv_rsp <= 1'b0;
            slv_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        wr_q       <= wr;
                        idx_q      <= addr[IDX_WIDTH-1:0];
                        wdata_q    <= wdata;
                        in_range_q <= in_range;
                        cnt        <= WAIT_LOAD;
                        state      <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CNT_LAST) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    slv_rsp <= 1'b1;
                    slv_err <= ~in_range_q;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_mem_array (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we),
        .idx     (idx_q),
        .wdata   (wdata_q),
        .rd_en   (mem_rd_en),
        .rd_clr  (mem_rd_clr),
        .rd_data (rdata)
    );

endmodule

// File: tb/tb_mem_slave.sv
// Scoreboard bench for mem_slave. It drives two instances: WAIT_CYCLES=1 (index 0) and WAIT_CYCLES=0 (index 1).
// Expected responses come from a plain array memory model and are queued per instance at issue time.
module tb_mem_slave;
    import mem_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MS = 16;

    logic clk = 1'b0;
    logic reset;

    logic          req_s   [2];
    logic          wr_s    [2];
    logic [AW-1:0] addr_s  [2];
    logic [DW-1:0] wdata_s [2];
    logic [DW-1:0] rdata_s [2];
    logic          rsp_s   [2];
    logic          err_s   [2];

    typedef struct {
        logic          is_read;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t mon_e0;
    exp_t mon_e1;

    logic [DW-1:0] ref_mem [2][MS];
    logic [DW-1:0] last_rd [2];

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] rnd_addr;

    always #5 clk = ~clk;

    mem_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .WAIT_CYCLES(1)
    ) dut_w1 (
        .clk(clk), .reset(reset), .req(req_s[0]), .wr(wr_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .rdata(rdata_s[0]), .slv_rsp(rsp_s[0]), .slv_err(err_s[0])
    );

    mem_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .WAIT_CYCLES(0)
    ) dut_w0 (
        .clk(clk), .reset(reset), .req(req_s[1]), .wr(wr_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .rdata(rdata_s[1]), .slv_rsp(rsp_s[1]), .slv_err(err_s[1])
    );

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mem_req_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_req_t r;
        r.wr    = w;
        r.addr  = a;
        r.wdata = d;
        return r;
    endfunction

    task automatic resetModel();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < MS; i++) ref_mem[d][i] = '0;
            last_rd[d] = '0;
        end
    endtask

    // Reference behaviour: in-range writes update the word, and reads return the word or 0 when out of range.
    // Every address at or above MS is an error, and rdata only changes on reads.
    task automatic modelStep(input int d, input mem_req_t r);
        exp_t e;
        e.is_read = !r.wr;
        e.err     = (int'(r.addr) >= MS);
        if (r.wr) begin
            if (!e.err) ref_mem[d][int'(r.addr)] = r.wdata;
            e.rdata = last_rd[d];
        end else begin
            e.rdata    = e.err ? '0 : ref_mem[d][int'(r.addr)];
            last_rd[d] = e.rdata;
        end
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Waits for the response. Latency is counted in rising edges after the capture edge.
    task automatic waitRsp(input int d, input int start);
        int  n;
        bit  got;
        int  exp_lat;
        n       = start;
        got     = 1'b0;
        exp_lat = (d == 0) ? 2 : 1;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (rsp_s[d] === 1'b1) got = 1'b1;
        end
        checkOutput((d == 0) ? "latency_w1" : "latency_w0", got ? DW'(n - 1) : DW'(999), DW'(exp_lat));
    endtask

    // Presents one request and returns at the negedge where slv_rsp is seen, leaving req high.
    task automatic applyStimulus(input int d, input mem_req_t r);
        req_s[d]   = 1'b1;
        wr_s[d]    = r.wr;
        addr_s[d]  = r.addr;
        wdata_s[d] = r.wdata;
        modelStep(d, r);
        @(posedge clk);
        waitRsp(d, 0);
    endtask

    task automatic dropReq(input int d);
        req_s[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor for the WAIT_CYCLES=1 instance: every response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rsp_s[0] === 1'b1) begin
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp_w1 actual=1 required=0 at %0t", $time);
            end else begin
                mon_e0 = exp_q0.pop_front();
                checkOutput("slv_err_w1", DW'(err_s[0]), DW'(mon_e0.err));
                if (mon_e0.is_read) checkOutput("rdata_w1", rdata_s[0], mon_e0.rdata);
            end
        end
    end

    // Monitor for the WAIT_CYCLES=0 instance.
    always @(negedge clk) begin
        if (rsp_s[1] === 1'b1) begin
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp_w0 actual=1 required=0 at %0t", $time);
            end else begin
                mon_e1 = exp_q1.pop_front();
                checkOutput("slv_err_w0", DW'(err_s[1]), DW'(mon_e1.err));
                if (mon_e1.is_read) checkOutput("rdata_w0", rdata_s[1], mon_e1.rdata);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_s[d]   = 1'b0;
            wr_s[d]    = 1'b0;
            addr_s[d]  = '0;
            wdata_s[d] = '0;
        end
        resetModel();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset_rdata", rdata_s[d], '0);
            checkOutput("reset_rsp", DW'(rsp_s[d]), '0);
            checkOutput("reset_err", DW'(err_s[d]), '0);
        end

        $display("[TB] directed accesses, WAIT_CYCLES=1");
        applyStimulus(0, mk(1'b1, 8'd3, 32'hDEADBEEF));
        applyStimulus(0, mk(1'b0, 8'd3, 32'h0));
        dropReq(0);
        idle(2);
        applyStimulus(0, mk(1'b0, 8'd5, 32'h0));
        applyStimulus(0, mk(1'b1, 8'd16, 32'h12345678));
        applyStimulus(0, mk(1'b0, 8'd0, 32'h0));
        applyStimulus(0, mk(1'b0, 8'd16, 32'h0));
        applyStimulus(0, mk(1'b0, 8'd255, 32'h0));
        applyStimulus(0, mk(1'b1, 8'd15, 32'hCAFEF00D));
        applyStimulus(0, mk(1'b0, 8'd15, 32'h0));
        dropReq(0);
        idle(1);

        $display("[TB] request changed while busy");
        req_s[0]   = 1'b1;
        wr_s[0]    = 1'b0;
        addr_s[0]  = 8'd3;
        wdata_s[0] = '0;
        modelStep(0, mk(1'b0, 8'd3, 32'h0));
        @(posedge clk);
        @(negedge clk);
        req_s[0] = 1'b0;
        #2;
        req_s[0]   = 1'b1;
        wr_s[0]    = 1'b1;
        addr_s[0]  = 8'd9;
        wdata_s[0] = 32'h11112222;
        waitRsp(0, 1);
        dropReq(0);
        idle(3);
        applyStimulus(0, mk(1'b0, 8'd9, 32'h0));
        applyStimulus(0, mk(1'b0, 8'd15, 32'h0));
        dropReq(0);
        idle(1);

        $display("[TB] reset during an in-flight write");
        req_s[0]   = 1'b1;
        wr_s[0]    = 1'b1;
        addr_s[0]  = 8'd2;
        wdata_s[0] = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        req_s[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        resetModel();
        checkOutput("rdata_after_reset", rdata_s[0], '0);
        idle(4);
        applyStimulus(0, mk(1'b0, 8'd2, 32'h0));
        dropReq(0);
        idle(1);

        $display("[TB] WAIT_CYCLES=0, req held high, alternating write/read");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, mk(1'b1, 8'd7, $urandom));
            applyStimulus(1, mk(1'b0, 8'd7, 32'h0));
        end
        dropReq(1);
        idle(1);

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            rnd_addr = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(16, 255)) : AW'($urandom_range(0, 15));
            applyStimulus(0, mk(1'($urandom_range(0, 1)), rnd_addr, $urandom));
            if ($urandom_range(0, 2) == 0) begin
                dropReq(0);
                idle($urandom_range(1, 3));
            end
        end
        dropReq(0);
        for (int i = 0; i < 25; i++) begin
            rnd_addr = AW'($urandom_range(0, 19));
            applyStimulus(1, mk(1'($urandom_range(0, 1)), rnd_addr, $urandom));
            if ($urandom_range(0, 3) == 0) begin
                dropReq(1);
                idle($urandom_range(1, 2));
            end
        end
        dropReq(1);
        idle(5);

        checkOutput("pending_w1", DW'(exp_q0.size()), '0);
        checkOutput("pending_w0", DW'(exp_q1.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
